// File: rtl/rv32i_fetch_unit.sv
// Purpose : RV32I instruction fetch front end; owns the PC, issues one imem request at a time, hands words to decode.
// Latency : best case 3 cycles per instruction (req+gnt N, rvalid N+1, o_fetch_valid N+2, next req N+3).
// Backpressure: the fetched entry is held stable in HOLD until i_decode_ready; fault entries hold until a redirect.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   o_imem_req/o_imem_addr    memory request (addr = PC), held until i_imem_gnt
//   i_imem_gnt                request accepted this cycle
//   i_imem_rvalid/_rdata/_err response channel (err qualified by rvalid)
//   i_redirect/i_redirect_pc  control-flow redirect, highest priority
//   o_fetch_valid/_instruction/_pc/_fault  entry presented to decode
//   i_decode_ready            decode accepts the presented entry
//   o_fetch_count             number of accepted non-fault instructions (wraps)

module rv32i_fetch_unit #(
    parameter int unsigned          INSTRUCTION_WIDTH = 32,
    parameter int unsigned          WORD_SIZE         = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC          = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    output logic                         o_imem_req,
    output logic [WORD_SIZE-1:0]         o_imem_addr,
    input  logic                         i_imem_gnt,
    input  logic                         i_imem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] i_imem_rdata,
    input  logic                         i_imem_err,
    input  logic                         i_redirect,
    input  logic [WORD_SIZE-1:0]         i_redirect_pc,
    output logic                         o_fetch_valid,
    output logic [INSTRUCTION_WIDTH-1:0] o_fetch_instruction,
    output logic [WORD_SIZE-1:0]         o_fetch_pc,
    output logic                         o_fetch_fault,
    input  logic                         i_decode_ready,
    output logic [31:0]                  o_fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(32'h0000_0013);

    state_t                         r_state;
    logic   [WORD_SIZE-1:0]         r_pc;
    logic   [INSTRUCTION_WIDTH-1:0] r_ir;
    logic                           r_drop;
    logic   [31:0]                  r_count;

    state_t                         w_state_nxt;
    logic   [WORD_SIZE-1:0]         w_pc_nxt;
    logic   [INSTRUCTION_WIDTH-1:0] w_ir_nxt;
    logic                           w_drop_nxt;
    logic   [31:0]                  w_count_nxt;

    logic                           w_req;
    logic                           w_gnt;
    logic                           w_misaligned;
    logic                           w_pending_after;

    // r_drop marks a request whose response must be thrown away. While it
    // is set no new request is raised, which keeps at most one request in
    // flight even when a redirect lands while memory still owes a response.
    assign w_req        = (r_state == S_REQ) && !r_drop;
    assign w_gnt        = w_req && i_imem_gnt;
    assign w_misaligned = |i_redirect_pc[1:0];

    // A response is still owed after this cycle if a grant is taken now, or
    // one was already owed and it does not arrive this cycle.
    assign w_pending_after = w_gnt ||
                             (((r_state == S_WAIT) || r_drop) && !i_imem_rvalid);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= NOP;
            r_drop  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_drop  <= w_drop_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_drop_nxt  = r_drop;
        w_count_nxt = r_count;

        // A stale response is consumed wherever it shows up.
        if (i_imem_rvalid && r_drop) begin
            w_drop_nxt = 1'b0;
        end

        if (i_redirect) begin
            // The held entry (if any) is discarded: no count, no pc+4.
            w_pc_nxt   = i_redirect_pc;
            w_drop_nxt = w_pending_after;
            if (w_misaligned) begin
                w_state_nxt = S_FAULT;
            end else if (w_gnt || ((r_state == S_WAIT) && !i_imem_rvalid)) begin
                w_state_nxt = S_WAIT;
            end else begin
                w_state_nxt = S_REQ;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (w_gnt) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_drop) begin
                            w_state_nxt = S_REQ;
                        end else if (i_imem_err) begin
                            w_state_nxt = S_FAULT;
                        end else begin
                            w_ir_nxt    = i_imem_rdata;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_decode_ready) begin
                        w_pc_nxt    = r_pc + WORD_SIZE'(4);
                        w_count_nxt = r_count + 32'd1;
                        w_state_nxt = S_REQ;
                    end
                end
                S_FAULT: begin
                    // Only a redirect leaves FAULT; decode ready is ignored.
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // All handshake outputs decode from registers only.
    assign o_imem_req          = w_req;
    assign o_imem_addr         = r_pc;
    assign o_fetch_valid       = (r_state == S_HOLD) || (r_state == S_FAULT);
    assign o_fetch_fault       = (r_state == S_FAULT);
    assign o_fetch_instruction = (r_state == S_HOLD) ? r_ir : NOP;
    assign o_fetch_pc          = r_pc;
    assign o_fetch_count       = r_count;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Purpose : directed bench for rv32i_fetch_unit with a behavioural instruction memory and an entry scoreboard.
// Latency : memory grant delay and response delay are adjustable per step.
// Backpressure: decode ready is driven directly by the directed sequence.

module tb_rv32i_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_fetch_valid;
    logic [31:0] o_fetch_instruction;
    logic [31:0] o_fetch_pc;
    logic        o_fetch_fault;
    logic        i_decode_ready;
    logic [31:0] o_fetch_count;

    rv32i_fetch_unit #(
        .INSTRUCTION_WIDTH (32),
        .WORD_SIZE         (32),
        .RESET_PC          (32'h0000_0000)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .o_imem_req          (o_imem_req),
        .o_imem_addr         (o_imem_addr),
        .i_imem_gnt          (i_imem_gnt),
        .i_imem_rvalid       (i_imem_rvalid),
        .i_imem_rdata        (i_imem_rdata),
        .i_imem_err          (i_imem_err),
        .i_redirect          (i_redirect),
        .i_redirect_pc       (i_redirect_pc),
        .o_fetch_valid       (o_fetch_valid),
        .o_fetch_instruction (o_fetch_instruction),
        .o_fetch_pc          (o_fetch_pc),
        .o_fetch_fault       (o_fetch_fault),
        .i_decode_ready      (i_decode_ready),
        .o_fetch_count       (o_fetch_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;     // accepted non-fault entries seen by the monitor
    int          n_grants = 0;

    // memory model knobs (written by the directed sequence only)
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    // memory model state
    logic        pend;
    logic        pend_err;
    logic [31:0] pend_addr;
    logic [31:0] gnt_addr;
    int          rcnt;
    int          gcnt;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h0010_0093 + (a << 12);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: drives on the falling edge, so the DUT samples stable values.
    always @(negedge clk) begin
        if (rst) begin
            i_imem_gnt    = 1'b0;
            i_imem_rvalid = 1'b0;
            i_imem_err    = 1'b0;
            i_imem_rdata  = 32'h0;
            pend          = 1'b0;
            gcnt          = 0;
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_err    = 1'b0;
            if (i_imem_gnt) begin
                pend      = 1'b1;
                pend_addr = gnt_addr;
                pend_err  = (gnt_addr == err_addr);
                rcnt      = rsp_delay;
                n_grants++;
            end
            if (pend) begin
                if (rcnt == 0) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_data(pend_addr);
                    i_imem_err    = pend_err;
                    pend          = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            i_imem_gnt = 1'b0;
            if (o_imem_req && !pend) begin
                if (gcnt >= gnt_delay) begin
                    i_imem_gnt = 1'b1;
                    gnt_addr   = o_imem_addr;
                    gcnt       = 0;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // Scoreboard: every accepted non-fault entry must match the queue head.
    always @(negedge clk) begin
        if (!rst && o_fetch_valid && !o_fetch_fault && i_decode_ready && !i_redirect) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", o_fetch_pc, e.pc);
                chk("sb_ins", o_fetch_instruction, e.ins);
            end
            acc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = mem_data(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!o_fetch_valid && n < 20);
        chk(tag, 32'(o_fetch_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!o_imem_req && n < 20);
        chk(tag, 32'(o_imem_req), 32'd1);
    endtask

    int g0;
    int base;

    initial begin
        rst            = 1'b1;
        i_redirect     = 1'b0;
        i_redirect_pc  = 32'h0;
        i_decode_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   32'(o_imem_req), 32'd0);
        chk("rst_addr",  o_imem_addr, 32'h0);
        chk("rst_valid", 32'(o_fetch_valid), 32'd0);
        chk("rst_fault", 32'(o_fetch_fault), 32'd0);
        chk("rst_ins",   o_fetch_instruction, NOP);
        chk("rst_pc",    o_fetch_pc, 32'h0);
        chk("rst_count", o_fetch_count, 32'h0);

        // Best-case back-to-back fetch
        push(32'h0);
        rst = 1'b0;                      // cycle 0: IDLE
        step();                          // cycle 1
        chk("c1_req",  32'(o_imem_req), 32'd1);
        chk("c1_addr", o_imem_addr, 32'h0);
        step();                          // cycle 2
        chk("c2_valid", 32'(o_fetch_valid), 32'd0);
        step();                          // cycle 3
        chk("c3_valid", 32'(o_fetch_valid), 32'd1);
        chk("c3_pc",    o_fetch_pc, 32'h0);
        step();                          // cycle 4
        chk("c4_req",   32'(o_imem_req), 32'd1);
        chk("c4_addr",  o_imem_addr, 32'h4);
        chk("c4_count", o_fetch_count, 32'd1);

        // Delayed grant and decode stall
        gnt_delay = 3;
        err_addr  = 32'h8;
        g0        = n_grants;
        push(32'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gw_req",  32'(o_imem_req), 32'd1);
            chk("gw_addr", o_imem_addr, 32'h4);
        end
        i_decode_ready = 1'b0;
        wait_valid("stall_valid_to");
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(o_fetch_valid), 32'd1);
            chk("stall_pc",    o_fetch_pc, 32'h4);
            chk("stall_ins",   o_fetch_instruction, mem_data(32'h4));
            step();
        end
        i_decode_ready = 1'b1;
        chk("stall_one_req", 32'(n_grants - g0), 32'd1);
        gnt_delay = 0;
        step();
        chk("stall_count", o_fetch_count, 32'd2);
        chk("next_addr",   o_imem_addr, 32'h8);

        // Access error at pc=8
        wait_valid("err_valid_to");
        chk("err_fault", 32'(o_fetch_fault), 32'd1);
        chk("err_pc",    o_fetch_pc, 32'h8);
        chk("err_ins",   o_fetch_instruction, NOP);
        err_addr = 32'hFFFF_FFFF;
        step();
        step();
        chk("err_hold",  32'(o_fetch_fault), 32'd1);
        chk("err_count", o_fetch_count, 32'd2);
        push(32'hC);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hC;
        step();
        i_redirect    = 1'b0;
        chk("err_clr_fault", 32'(o_fetch_fault), 32'd0);
        chk("err_clr_addr",  o_imem_addr, 32'hC);
        wait_valid("c_valid_to");

        // Redirect while waiting; stale response arrives late
        step();
        rsp_delay = 2;
        chk("w_addr", o_imem_addr, 32'h10);
        step();
        chk("w_req_low", 32'(o_imem_req), 32'd0);
        push(32'h100);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        step();
        i_redirect    = 1'b0;
        rsp_delay     = 0;
        chk("w_still_wait", 32'(o_imem_req), 32'd0);
        wait_req("w_req_to");
        chk("w_new_addr", o_imem_addr, 32'h100);
        wait_valid("w_valid_to");

        // Redirect in HOLD together with ready
        wait_valid("h_valid_to");
        chk("h_pc", o_fetch_pc, 32'h104);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h180;
        step();
        i_redirect    = 1'b0;
        chk("h_count", o_fetch_count, 32'(acc_cnt));
        chk("h_req",   32'(o_imem_req), 32'd1);
        chk("h_addr",  o_imem_addr, 32'h180);

        // Misaligned redirect
        i_decode_ready = 1'b0;
        wait_valid("m_valid_to");
        chk("m_hold_pc",  o_fetch_pc, 32'h180);
        chk("m_hold_ins", o_fetch_instruction, mem_data(32'h180));
        g0            = n_grants;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h102;
        step();
        i_redirect     = 1'b0;
        i_decode_ready = 1'b1;
        chk("m_valid", 32'(o_fetch_valid), 32'd1);
        chk("m_fault", 32'(o_fetch_fault), 32'd1);
        chk("m_ins",   o_fetch_instruction, NOP);
        chk("m_pc",    o_fetch_pc, 32'h102);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("m_hold_fault", 32'(o_fetch_fault), 32'd1);
            chk("m_hold_pc2",   o_fetch_pc, 32'h102);
            chk("m_no_req",     32'(o_imem_req), 32'd0);
        end
        chk("m_no_grant", 32'(n_grants - g0), 32'd0);
        chk("m_count",    o_fetch_count, 32'(acc_cnt));
        push(32'h200);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        step();
        i_redirect    = 1'b0;
        chk("m_res_fault", 32'(o_fetch_fault), 32'd0);
        chk("m_res_addr",  o_imem_addr, 32'h200);
        wait_valid("m_res_valid_to");

        // Reset in the middle of an outstanding request
        step();
        rsp_delay = 3;
        step();
        rst = 1'b1;
        #1;
        chk("ar_req",   32'(o_imem_req), 32'd0);
        chk("ar_valid", 32'(o_fetch_valid), 32'd0);
        chk("ar_pc",    o_fetch_pc, 32'h0);
        chk("ar_count", o_fetch_count, 32'h0);
        step();
        step();
        rsp_delay = 0;
        base      = acc_cnt;
        push(32'h0);
        rst = 1'b0;
        wait_valid("ar_valid_to");
        chk("ar_first_pc", o_fetch_pc, 32'h0);
        step();
        chk("ar_count1", o_fetch_count, 32'(acc_cnt - base));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
